// File: rtl/dir_packetizer_pkg.sv
// rtl/dir_packetizer_pkg.sv - message encodings, data-message predicate and header field offsets
package dir_packetizer_pkg;

  localparam int MSG_ENC_BITS = 4;

  localparam logic [MSG_ENC_BITS-1:0] NO_MSG     = 4'd0;
  localparam logic [MSG_ENC_BITS-1:0] GET_S      = 4'd1;
  localparam logic [MSG_ENC_BITS-1:0] GET_M      = 4'd2;
  localparam logic [MSG_ENC_BITS-1:0] PUT_S      = 4'd3;
  localparam logic [MSG_ENC_BITS-1:0] PUT_M      = 4'd4;
  localparam logic [MSG_ENC_BITS-1:0] DATA       = 4'd5;
  localparam logic [MSG_ENC_BITS-1:0] DATA_S     = 4'd6;
  localparam logic [MSG_ENC_BITS-1:0] RESP_PUT_M = 4'd7;
  localparam logic [MSG_ENC_BITS-1:0] INV        = 4'd8;
  localparam logic [MSG_ENC_BITS-1:0] INV_ACK    = 4'd9;
  localparam logic [MSG_ENC_BITS-1:0] FWD_GET_S  = 4'd10;
  localparam logic [MSG_ENC_BITS-1:0] FWD_GET_M  = 4'd11;
  localparam logic [MSG_ENC_BITS-1:0] PUT_ACK    = 4'd12;

  // Width of the payload flit count field in the header
  localparam int HDR_COUNT_BITS = 4;
  localparam int HDR_MSG_LSB    = 0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_ADDR,
    S_DATA
  } pkt_state_t;

  // Header field offsets depend on the message and node-ID widths
  function automatic int hdr_src_lsb(input int msg_bits);
    return msg_bits;
  endfunction

  function automatic int hdr_dest_lsb(input int msg_bits, input int id_bits);
    return msg_bits + id_bits;
  endfunction

  function automatic int hdr_count_lsb(input int msg_bits, input int id_bits);
    return msg_bits + 2 * id_bits;
  endfunction

  // Messages that carry a full cache line behind the address flit
  function automatic logic msg_has_data(input logic [15:0] m);
    return (m == 16'(DATA)) || (m == 16'(DATA_S)) ||
           (m == 16'(PUT_M)) || (m == 16'(RESP_PUT_M));
  endfunction

endpackage

// File: rtl/dir_packetizer.sv
// rtl/dir_packetizer.sv - directory message to NoC flit packetizer; DIR_PKT_STATS_EN adds pkt/stall counters
module dir_packetizer
  import dir_packetizer_pkg::*;
#(
  parameter int OFFSET_BITS    = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDRESS_BITS   = 32,
  parameter int MSG_BITS       = 4,
  parameter int SHARER_ID_BITS = 3,
  parameter int SRC_ID         = 0
) (
  input  logic                                clock,
  input  logic                                reset,
  input  logic [MSG_BITS-1:0]                 msg_in,
  input  logic [ADDRESS_BITS-1:0]             address_in,
  input  logic [(DATA_WIDTH<<OFFSET_BITS)-1:0] data_in,
  input  logic [SHARER_ID_BITS-1:0]           dest_id_in,
  output logic                                packetizer_busy,
  output logic [DATA_WIDTH-1:0]               flit_out,
  output logic                                flit_valid,
  input  logic                                flit_ready
`ifdef DIR_PKT_STATS_EN
  ,
  output logic [31:0]                         pkt_count,
  output logic [31:0]                         stall_count
`endif
);

  localparam int WORDS  = 1 << OFFSET_BITS;
  localparam int LINE_W = DATA_WIDTH << OFFSET_BITS;
  localparam int SRC_LSB   = hdr_src_lsb(MSG_BITS);
  localparam int DEST_LSB  = hdr_dest_lsb(MSG_BITS, SHARER_ID_BITS);
  localparam int COUNT_LSB = hdr_count_lsb(MSG_BITS, SHARER_ID_BITS);
  localparam logic [HDR_COUNT_BITS-1:0] DATA_CNT = HDR_COUNT_BITS'(1 + WORDS);
  localparam logic [MSG_BITS-1:0]       IDLE_MSG = MSG_BITS'(NO_MSG);

  pkt_state_t                 state_q, state_d;
  logic [MSG_BITS-1:0]        msg_q;
  logic [ADDRESS_BITS-1:0]    addr_q;
  logic [LINE_W-1:0]          data_q;
  logic [SHARER_ID_BITS-1:0]  dest_q;
  logic [OFFSET_BITS-1:0]     word_q;
  logic [DATA_WIDTH-1:0]      header;

  logic capture;
  logic handshake;
  logic has_data;
  logic last_word;
  logic final_hs;

  assign capture   = (state_q == S_IDLE) && (msg_in != IDLE_MSG);
  assign handshake = flit_valid && flit_ready;
  assign has_data  = msg_has_data(16'(msg_q));
  assign last_word = (word_q == {OFFSET_BITS{1'b1}});
  assign final_hs  = handshake &&
                     (((state_q == S_ADDR) && !has_data) ||
                      ((state_q == S_DATA) && last_word));

  // Packet FSM state register; reset aborts any packet in flight
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: header, address, then the line words for data messages
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (capture) state_d = S_HEADER;
      S_HEADER: if (handshake) state_d = S_ADDR;
      S_ADDR:   if (handshake) state_d = has_data ? S_DATA : S_IDLE;
      S_DATA:   if (handshake && last_word) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Captured message fields and word counter; the counter wraps back to 0 on the last word
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      msg_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      dest_q <= '0;
      word_q <= '0;
    end else if (capture) begin
      msg_q  <= msg_in;
      addr_q <= address_in;
      data_q <= data_in;
      dest_q <= dest_id_in;
      word_q <= '0;
    end else if ((state_q == S_DATA) && handshake) begin
      word_q <= word_q + 1'b1;
    end
  end

  // Header flit: msg, source, destination, payload flit count, zero padding
  always_comb begin
    header = '0;
    header[HDR_MSG_LSB +: MSG_BITS]         = msg_q;
    header[SRC_LSB +: SHARER_ID_BITS]       = SHARER_ID_BITS'(SRC_ID);
    header[DEST_LSB +: SHARER_ID_BITS]      = dest_q;
    header[COUNT_LSB +: HDR_COUNT_BITS]     = has_data ? DATA_CNT : HDR_COUNT_BITS'(1);
  end

  // Outputs decode from registered state and captured fields, so they hold during a stall
  always_comb begin
    packetizer_busy = 1'b0;
    flit_valid      = 1'b0;
    flit_out        = '0;
    case (state_q)
      S_HEADER: begin
        packetizer_busy = 1'b1;
        flit_valid      = 1'b1;
        flit_out        = header;
      end
      S_ADDR: begin
        packetizer_busy = 1'b1;
        flit_valid      = 1'b1;
        flit_out        = DATA_WIDTH'(addr_q);
      end
      S_DATA: begin
        packetizer_busy = 1'b1;
        flit_valid      = 1'b1;
        flit_out        = data_q[DATA_WIDTH*int'(word_q) +: DATA_WIDTH];
      end
      default: begin
        packetizer_busy = 1'b0;
      end
    endcase
  end

`ifdef DIR_PKT_STATS_EN
  // Completed-packet and back-pressure counters, free-running with natural wrap
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pkt_count   <= '0;
      stall_count <= '0;
    end else begin
      if (final_hs) pkt_count <= pkt_count + 32'd1;
      if (flit_valid && !flit_ready) stall_count <= stall_count + 32'd1;
    end
  end
`else
  logic unused_final_hs;
  assign unused_final_hs = final_hs;
`endif

endmodule

// File: tb/tb_dir_packetizer.sv
// tb/tb_dir_packetizer.sv - directed and randomized self-checking bench for dir_packetizer
module tb_dir_packetizer;
  import dir_packetizer_pkg::*;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   msg_in = '0;
  logic [31:0]  address_in = '0;
  logic [127:0] data_in = '0;
  logic [2:0]   dest_id_in = '0;
  logic         packetizer_busy;
  logic [31:0]  flit_out;
  logic         flit_valid;
  logic         flit_ready = 1'b0;
`ifdef DIR_PKT_STATS_EN
  logic [31:0]  pkt_count;
  logic [31:0]  stall_count;
`endif

  int total = 0;
  int bad = 0;
  int exp_pkts = 0;
  int exp_stalls = 0;
  logic [31:0] expq[$];

  always #5 clock = ~clock;

  dir_packetizer dut (
    .clock          (clock),
    .reset          (reset),
    .msg_in         (msg_in),
    .address_in     (address_in),
    .data_in        (data_in),
    .dest_id_in     (dest_id_in),
    .packetizer_busy(packetizer_busy),
    .flit_out       (flit_out),
    .flit_valid     (flit_valid),
    .flit_ready     (flit_ready)
`ifdef DIR_PKT_STATS_EN
    ,
    .pkt_count      (pkt_count),
    .stall_count    (stall_count)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_stats(input string tag);
`ifdef DIR_PKT_STATS_EN
    chk({tag, "_pkt_count"}, 64'(pkt_count), 64'(exp_pkts));
    chk({tag, "_stall_count"}, 64'(stall_count), 64'(exp_stalls));
`endif
  endtask

  function automatic bit carries_data(input logic [3:0] m);
    return (m == DATA) || (m == DATA_S) || (m == PUT_M) || (m == RESP_PUT_M);
  endfunction

  // Expected flit stream: header, address, then 4 words low to high for data messages
  task automatic build(input logic [3:0] m, input logic [31:0] a,
                       input logic [127:0] d, input logic [2:0] dst);
    int cnt;
    logic [31:0] hdr;
    cnt = carries_data(m) ? 5 : 1;
    hdr = 32'(m) + (32'(dst) * 128) + (32'(cnt) * 1024);
    expq.delete();
    expq.push_back(hdr);
    expq.push_back(a);
    if (carries_data(m)) begin
      for (int w = 0; w < 4; w++) expq.push_back(32'(d >> (32 * w)));
    end
  endtask

  // Called at a negedge with the block idle; returns at the negedge after the final handshake
  task automatic run_packet(input string tag, input logic [3:0] m, input logic [31:0] a,
                            input logic [127:0] d, input logic [2:0] dst,
                            input bit rnd_ready, input int stall_at, input int stall_len,
                            input bit noise);
    int idx, cycles, stalled, pkt_stalls, n;
    bit rdy;
    build(m, a, d, dst);
    n = expq.size();
    chk({tag, "_busy_before"}, 64'(packetizer_busy), 64'd0);
    msg_in = m; address_in = a; data_in = d; dest_id_in = dst;
    @(negedge clock);
    msg_in = noise ? FWD_GET_S : NO_MSG;
    address_in = $urandom; dest_id_in = 3'($urandom);
    idx = 0; cycles = 0; stalled = 0; pkt_stalls = 0;
    while (idx < n && cycles < 200) begin
      chk({tag, "_busy"}, 64'(packetizer_busy), 64'd1);
      chk({tag, "_valid"}, 64'(flit_valid), 64'd1);
      chk($sformatf("%s_flit%0d", tag, idx), 64'(flit_out), 64'(expq[idx]));
      if (rnd_ready) rdy = ($urandom_range(0, 3) != 0);
      else rdy = !(idx == stall_at && stalled < stall_len);
      flit_ready = rdy;
      if (rdy) idx++;
      else begin
        stalled++;
        pkt_stalls++;
        exp_stalls++;
      end
      cycles++;
      @(negedge clock);
    end
    chk({tag, "_all_flits"}, 64'(idx), 64'(n));
    flit_ready = 1'b0;
    msg_in = NO_MSG;
    exp_pkts++;
    chk({tag, "_busy_after"}, 64'(packetizer_busy), 64'd0);
    chk({tag, "_valid_after"}, 64'(flit_valid), 64'd0);
    chk({tag, "_busy_cycles"}, 64'(cycles), 64'(n + pkt_stalls));
    chk_stats(tag);
  endtask

  task automatic idle_cycles(input string tag, input int k);
    for (int i = 0; i < k; i++) begin
      flit_ready = 1'($urandom);
      chk({tag, "_idle_valid"}, 64'(flit_valid), 64'd0);
      chk({tag, "_idle_busy"}, 64'(packetizer_busy), 64'd0);
      @(negedge clock);
    end
    flit_ready = 1'b0;
  endtask

  localparam logic [127:0] LINE = 128'h00000001_00000002_00000003_00000004;

  initial begin
    // Reset state
    @(negedge clock);
    chk("rst_busy", 64'(packetizer_busy), 64'd0);
    chk("rst_valid", 64'(flit_valid), 64'd0);
    chk("rst_flit", 64'(flit_out), 64'd0);
    chk_stats("rst");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);

    // Data line, always ready: 6 consecutive flits
    run_packet("data", DATA, 32'h00000100, LINE, 3'd3, 1'b0, -1, 0, 1'b0);
    idle_cycles("data", 2);

    // Inv: header and address only
    run_packet("inv", INV, 32'h00000100, '0, 3'd7, 1'b0, -1, 0, 1'b0);
    idle_cycles("inv", 2);

    // Stall 3 cycles on the 2nd data flit
    run_packet("stall", DATA, 32'h00000100, LINE, 3'd3, 1'b0, 3, 3, 1'b0);
    idle_cycles("stall", 2);

    // FwdGetS presented while busy must be dropped
    run_packet("ignore", DATA, 32'h00000100, LINE, 3'd3, 1'b0, -1, 0, 1'b1);
    idle_cycles("ignore", 3);

    // Back-to-back: second message waits for busy low and is taken at once
    run_packet("b2b_a", PUT_M, 32'h0000abcd, 128'h11111111_22222222_33333333_44444444, 3'd1,
               1'b0, -1, 0, 1'b1);
    run_packet("b2b_b", GET_S, 32'h00001234, '0, 3'd2, 1'b0, -1, 0, 1'b0);
    idle_cycles("b2b", 1);

    // Reset during the 2nd data flit aborts the packet
    build(DATA, 32'h00000100, LINE, 3'd3);
    msg_in = DATA; address_in = 32'h00000100; data_in = LINE; dest_id_in = 3'd3;
    @(negedge clock);
    msg_in = NO_MSG;
    flit_ready = 1'b1;
    repeat (3) @(negedge clock);
    chk("rstmid_flit3", 64'(flit_out), 64'(expq[3]));
    #2 reset = 1'b0;
    #1;
    chk("rstmid_valid", 64'(flit_valid), 64'd0);
    chk("rstmid_busy", 64'(packetizer_busy), 64'd0);
    chk("rstmid_flit", 64'(flit_out), 64'd0);
    exp_pkts = 0;
    exp_stalls = 0;
    chk_stats("rstmid");
    @(negedge clock);
    reset = 1'b1;
    idle_cycles("rstmid", 5);

    // Randomized traffic against the flit-stream model
    for (int p = 0; p < 24; p++) begin
      logic [3:0]   m;
      logic [127:0] d;
      m = 4'($urandom_range(1, 12));
      d = {$urandom, $urandom, $urandom, $urandom};
      run_packet($sformatf("rnd%0d", p), m, $urandom, d, 3'($urandom),
                 1'b1, -1, 0, 1'($urandom));
      idle_cycles("rnd", $urandom_range(0, 2));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dir_packetizer.md
DIR_PACKETIZER -- requirements
Module: dir_packetizer

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- OFFSET_BITS, 2: log2 words per cache line.
- DATA_WIDTH, 32: word width; also the flit width.
- ADDRESS_BITS, 32: address width; SHALL be at most DATA_WIDTH.
- MSG_BITS, 4: coherence message width.
- SHARER_ID_BITS, 3: node ID width.
- SRC_ID, 0: this directory's node ID.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clock, in, 1: the single clock.
- reset, in, 1: asynchronous, active-low reset.
- msg_in, in, MSG_BITS: message from the directory controller; NoMsg means idle.
- address_in, in, ADDRESS_BITS: line address.
- data_in, in, DATA_WIDTH<<OFFSET_BITS: line data.
- dest_id_in, in, SHARER_ID_BITS: destination node.
- packetizer_busy, out, 1: high while a packet is in flight; the input is ignored while it is high.
- flit_out, out, DATA_WIDTH: NoC flit.
- flit_valid, out, 1: flit_out is valid.
- flit_ready, in, 1: the NoC accepts the flit.

Function
REQ-003 The block SHALL capture msg_in, address_in, data_in and dest_id_in on a rising edge where msg_in != NoMsg and packetizer_busy=0.
REQ-004 The block SHALL set packetizer_busy=1 registered, in the cycle after capture.
REQ-005 The header flit SHALL appear with flit_valid=1 in the cycle after capture (latency 1).
REQ-006 The FSM SHALL have the states IDLE, HEADER, ADDR and DATA, with these transitions:
- IDLE->HEADER on capture.
- HEADER->ADDR on handshake.
- ADDR->DATA on handshake when the message carries data.
- ADDR->IDLE on handshake when it does not.
- DATA->IDLE on handshake of the last word.
REQ-007 A handshake SHALL be flit_valid & flit_ready at a rising edge.
REQ-008 While flit_valid=1 and flit_ready=0, flit_out SHALL hold stable.
REQ-009 The header flit layout (LSB first) SHALL be:
- msg [MSG_BITS-1:0]
- SRC_ID
- captured dest_id
- a 4-bit payload flit count: 1 + words if the message carries data, else 1
- zeros in all remaining bits.
REQ-010 The address flit SHALL be the captured address, zero-extended to DATA_WIDTH.
REQ-011 Data flits SHALL be sent word 0 (data_in[DATA_WIDTH-1:0]) first, ascending.
- A word counter of OFFSET_BITS width SHALL wrap exactly at the last word.
REQ-012 Data, DataS, PutM and RespPutM SHALL be the data-carrying messages; all others SHALL be header+address only.
REQ-013 packetizer_busy SHALL fall in the cycle after the final handshake.
- A new message SHALL be accepted in that same cycle.
- The minimum idle gap between packets SHALL therefore be 1 cycle.
REQ-014 An input presented while packetizer_busy=1 SHALL be ignored and not queued.
- The directory controller holds its output until busy is low.
REQ-015 flit_ready asserted while flit_valid=0 SHALL have no effect.

Reset
REQ-016 While reset=0, the block SHALL hold the following:
- state IDLE
- packetizer_busy=0
- flit_valid=0
- flit_out=0
- word counter 0
- all captured registers 0.
REQ-017 Reset asserted mid-packet SHALL abort the packet immediately (asynchronously); no remaining flits SHALL be emitted after release.

Configuration
REQ-018 When the macro DIR_PKT_STATS_EN is defined, the block SHALL add these outputs:
- pkt_count [31:0]: incremented on each final handshake.
- stall_count [31:0]: incremented on each cycle with flit_valid=1 and flit_ready=0.
- Both SHALL reset to 0 and wrap at 2^32.
REQ-019 Without DIR_PKT_STATS_EN, these ports and counters SHALL be absent, and the block's behaviour SHALL otherwise be identical.

Structure
REQ-020 The shared include file SHALL hold the following:
- message encodings (NoMsg, Data, DataS, GetS, GetM, PutM, RespPutM, Inv, InvAck, FwdGetS, ...)
- a msg_has_data function
- header field offset constants.
REQ-021 The block SHALL be a single module with no sub-modules; the packet FSM, word counter and header builder are inline.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Data, address 32'h00000100, dest 3, data 128'h00000001_00000002_00000003_00000004, flit_ready=1 -> flits header(count 5), 00000100, 00000004, 00000003, 00000002, 00000001 on consecutive cycles; busy high for exactly 6 cycles.
- Inv, address 32'h00000100, dest 7 -> header(count 1) then 00000100; busy falls 1 cycle after the address handshake.
- Same Data packet with flit_ready held low 3 cycles on the 2nd data flit -> flit_out stable across the stall; stall_count=3 when DIR_PKT_STATS_EN is defined.
- FwdGetS issued while busy=1 -> ignored; only the first packet appears; pkt_count increments by 1.
- Back-to-back: second msg held until busy low -> accepted in the first idle cycle; header appears the following cycle.
- Reset driven low during the 2nd data flit -> flit_valid=0 and busy=0 immediately; no flits after release until a new msg_in arrives.
